evict_ram: RTL
==============

Name: evict_ram

Overview:
- Parametrised read-before-write storage for the CAM path.
- Each accepted write returns the word it displaced as an eviction record (data and address), so the CAM match logic can erase the stale key.
- Adds per-entry valid tracking, an explicit invalidate request, valid/ready handshakes on every interface, and a post-reset clear sweep.
- Sits between the CAM write controller and the CAM match-erase logic.

Parameters:
- DATA_WIDTH, 8, width of stored word.
- ADDR_WIDTH, 2, address width; depth = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at rising edge.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- inv_valid  in  1  invalidate request.
- inv_ready  out  1  invalidate accepted when inv_valid && inv_ready.
- inv_addr  in  ADDR_WIDTH  entry to invalidate.
- ev_valid  out  1  eviction record available.
- ev_ready  in  1  consumer takes record when ev_valid && ev_ready.
- ev_addr  out  ADDR_WIDTH  address of evicted entry.
- ev_data  out  DATA_WIDTH  displaced word.
- busy  out  1  high in INIT and EVICT states.
- init_done  out  1  high once the clear sweep has completed; stays high until next rst.

Behaviour:
- Reset values: wr_ready=0, inv_ready=0, ev_valid=0, ev_addr=0, ev_data=0, busy=1, init_done=0. The FSM enters INIT on the cycle after rst is sampled high. rst takes priority over everything, including mid-EVICT; a pending record is dropped.
- INIT: clears one entry per cycle (data=0, valid=0), sweeping addresses 0..2**ADDR_WIDTH-1 upward, so the sweep takes exactly 2**ADDR_WIDTH cycles. On the cycle after the last address: IDLE, init_done=1, busy=0.
- IDLE:
  - wr_ready=1; inv_ready = !wr_valid (write has priority; never both accepted in one cycle).
  - Accepted write at edge N: old data and valid bit of wr_addr are captured, wr_data is written, and the valid bit is set, all at edge N.
  - If the old valid bit was 1: go to EVICT. From cycle N+1, ev_valid=1, ev_addr=wr_addr, ev_data=old data.
  - If the old valid bit was 0: stay in IDLE; no record is produced and back-to-back writes are allowed.
  - Accepted invalidate: the valid bit is cleared and data is kept. If the entry was valid, go to EVICT with its data and address; if not, the request is a no-op and the FSM stays in IDLE.
- EVICT:
  - wr_ready=0, inv_ready=0, busy=1.
  - ev_valid, ev_addr and ev_data are held stable until ev_ready. The handshake edge returns the FSM to IDLE, where it accepts requests on the next cycle.
  - Minimum write-to-write spacing with an eviction is 2 cycles when ev_ready is tied high.
- Writing the same address twice evicts the first value on the second write. Rewriting the same data still evicts, with no compare.
- Addresses wrap naturally within ADDR_WIDTH; there are no out-of-range cases.
- A request whose valid is held high while ready=0 must keep its address and data stable; this is the source's obligation and is not checked by the block.
- Storage is a single array of DATA_WIDTH+1 bits per entry: data plus valid bit.

Optional Feature:
- Macro: EVICT_RAM_STATS_EN.
- When defined: adds output ev_count (16 bits). It resets to 0 when rst is sampled high and increments by 1 on each ev_valid && ev_ready handshake, saturating at 16'hFFFF. It also adds output occ_count (ADDR_WIDTH+1 bits): the number of valid entries, reset to 0. occ_count increments on a write to an invalid entry, decrements on an invalidate of a valid entry, and is unchanged on a write to a valid entry.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset and sweep: assert rst for 1 cycle with defaults -> busy=1 for 4 cycles of INIT, then init_done=1, wr_ready=1; with stats enabled, occ_count=0.
- Fresh write: write addr 2 data 8'hA5 -> no ev_valid in the next 3 cycles; wr_ready stays 1; a second write to addr 3 is accepted on the following cycle.
- Overwrite with eviction: write addr 2 = 8'h3C after 8'hA5 -> one cycle later ev_valid=1, ev_addr=2, ev_data=8'hA5; wr_ready=0 until the ev handshake.
- Backpressure: hold ev_ready=0 for 5 cycles during an eviction -> ev_valid, ev_addr and ev_data are stable and wr_ready=0 throughout; ev_ready=1 -> IDLE next cycle; with stats enabled, ev_count increments by exactly 1.
- Invalidate: assert wr_valid and inv_valid together -> write accepted, inv_ready=0. Then invalidate addr 2 -> eviction of 8'h3C at addr 2. Invalidate addr 2 again -> no ev_valid. Write addr 2 = 8'h11 -> no eviction.
- Reset mid-EVICT: rst during ev_valid=1 with ev_ready=0 -> ev_valid=0 on the next cycle, INIT re-runs, and all entries read back as invalid (subsequent writes to each address produce no eviction).

Source files
------------

// File: rtl/evict_ram.sv
// evict_ram: read-before-write store returning displaced words as eviction records.
// Optional EVICT_RAM_STATS_EN adds ev_count and occ_count outputs.
module evict_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  inv_valid,
  output logic                  inv_ready,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [ADDR_WIDTH-1:0] ev_addr,
  output logic [DATA_WIDTH-1:0] ev_data,
`ifdef EVICT_RAM_STATS_EN
  output logic [15:0]           ev_count,
  output logic [ADDR_WIDTH:0]   occ_count,
`endif
  output logic                  busy,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_EVICT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  init_done_q;
  logic [ADDR_WIDTH-1:0] ev_addr_q;
  logic [DATA_WIDTH-1:0] ev_data_q;

  // Each entry: {valid, data}
  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH:0]   rd_word;
  logic                  old_vld;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH:0]   mem_wdata;
  logic                  ev_load;
  logic                  wr_acc;
  logic                  inv_acc;

  assign rd_addr = wr_valid ? wr_addr : inv_addr;
  assign rd_word = mem_q[rd_addr];
  assign old_vld = rd_word[DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    inv_ready = 1'b0;
    busy      = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = init_addr_q;
    mem_wdata = '0;
    ev_load   = 1'b0;
    wr_acc    = 1'b0;
    inv_acc   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        if (init_addr_q == LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        busy      = 1'b0;
        wr_ready  = 1'b1;
        inv_ready = !wr_valid;
        if (wr_valid) begin
          wr_acc    = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = wr_addr;
          mem_wdata = {1'b1, wr_data};
        end else if (inv_valid) begin
          inv_acc   = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = inv_addr;
          mem_wdata = {1'b0, rd_word[DATA_WIDTH-1:0]};
        end
        if ((wr_acc || inv_acc) && old_vld) begin
          ev_load = 1'b1;
          state_d = S_EVICT;
        end
      end
      S_EVICT: begin
        if (ev_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      ev_addr_q   <= '0;
      ev_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        init_addr_q <= init_addr_q + 1'b1;
        if (init_addr_q == LAST) init_done_q <= 1'b1;
      end
      if (ev_load) begin
        ev_addr_q <= rd_addr;
        ev_data_q <= rd_word[DATA_WIDTH-1:0];
      end
    end
  end

  // Storage has no reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ev_valid  = (state_q == S_EVICT);
  assign ev_addr   = ev_addr_q;
  assign ev_data   = ev_data_q;
  assign init_done = init_done_q;

`ifdef EVICT_RAM_STATS_EN
  logic [15:0]         ev_count_q;
  logic [ADDR_WIDTH:0] occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_count_q <= '0;
      occ_q      <= '0;
    end else begin
      if (ev_valid && ev_ready && ev_count_q != 16'hFFFF)
        ev_count_q <= ev_count_q + 16'd1;
      if (wr_acc && !old_vld)
        occ_q <= occ_q + 1'b1;
      else if (inv_acc && old_vld)
        occ_q <= occ_q - 1'b1;
    end
  end

  assign ev_count  = ev_count_q;
  assign occ_count = occ_q;
`endif

endmodule
